// File: rtl/divider_pkg.sv
// Shared types and constants for the serial signed divider.
package divider_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    FIX
  } div_state_e;

  localparam int DIV_W     = 32;
  localparam int DIV_CNT_W = $clog2(DIV_W) + 1;

endpackage

// File: rtl/div_sub_stage.sv
// Trial subtract for the restoring divider: WIDTH+1-bit difference plus a non-negative flag.
module div_sub_stage #(
  parameter int W = 32
) (
  input  logic [W:0] minuend,
  input  logic [W:0] subtrahend,
  output logic [W:0] diff,
  output logic       nonneg
);

  assign diff   = minuend - subtrahend;
  assign nonneg = ~diff[W];

endmodule

// File: rtl/signed_divider.sv
// Serial radix-2 restoring signed divider, one quotient bit per clock, sign-magnitude.
// Optional: define SIGNED_DIVIDER_EARLY_DBZ_EN to skip the iterations for a zero divisor.
//
// state | meaning
// IDLE  | waiting for start, last result held on q/r/dbz
// CALC  | WIDTH shift/subtract iterations
// FIX   | apply signs or divide-by-zero forcing, pulse done
module signed_divider
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             dbz
);

  localparam int CNT_W = $clog2(WIDTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  div_state_e       state;
  logic [WIDTH-1:0] dvd;
  logic [WIDTH-1:0] divisor;
  // The remainder stays below |divisor| <= 2^(WIDTH-1), so WIDTH bits of storage
  // suffice; the subtractor itself carries the extra sign bit.
  logic [WIDTH-1:0] rem;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH-1:0] a_lat;
  logic             sign_q;
  logic             sign_r;
  logic             zero;

  logic [WIDTH:0]   shifted;
  logic [WIDTH:0]   trial;
  logic             nonneg;

  function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
    return v[WIDTH-1] ? -v : v;
  endfunction

  assign shifted = {rem, dvd[WIDTH-1]};

  div_sub_stage #(.W(WIDTH)) u_sub (
    .minuend   (shifted),
    .subtrahend({1'b0, divisor}),
    .diff      (trial),
    .nonneg    (nonneg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      dvd     <= '0;
      divisor <= '0;
      rem     <= '0;
      cnt     <= '0;
      a_lat   <= '0;
      sign_q  <= 1'b0;
      sign_r  <= 1'b0;
      zero    <= 1'b0;
      q       <= '0;
      r       <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
      dbz     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd     <= mag(a);
            divisor <= mag(b);
            a_lat   <= a;
            sign_q  <= a[WIDTH-1] ^ b[WIDTH-1];
            sign_r  <= a[WIDTH-1];
            zero    <= (b == '0);
            rem     <= '0;
            cnt     <= '0;
            busy    <= 1'b1;
`ifdef SIGNED_DIVIDER_EARLY_DBZ_EN
            state   <= (b == '0) ? FIX : CALC;
`else
            state   <= CALC;
`endif
          end
        end
        CALC: begin
          rem <= nonneg ? trial[WIDTH-1:0] : shifted[WIDTH-1:0];
          dvd <= {dvd[WIDTH-2:0], nonneg};
          cnt <= cnt + CNT_W'(1);
          if (cnt == LAST_CNT) state <= FIX;
        end
        FIX: begin
          if (zero) begin
            q   <= '1;
            r   <= a_lat;
            dbz <= 1'b1;
          end else begin
            q   <= sign_q ? -dvd : dvd;
            r   <= sign_r ? -rem : rem;
            dbz <= 1'b0;
          end
          done  <= 1'b1;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_signed_divider.sv
// Self-checking bench for signed_divider: vector table plus start/reset corner sequences.
module tb_signed_divider;

`ifdef SIGNED_DIVIDER_EARLY_DBZ_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic [31:0] q, r;
  logic        busy, done, dbz;

  int errors = 0;
  int checks = 0;

  signed_divider #(.WIDTH(32)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .start(start),
    .a    (a),
    .b    (b),
    .q    (q),
    .r    (r),
    .busy (busy),
    .done (done),
    .dbz  (dbz)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [31:0] r;
    logic        dbz;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // drives start for one edge; returns #1 after the accepting edge
  task automatic launch(input logic [31:0] av, input logic [31:0] bv);
    a = av;
    b = bv;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a = $urandom;
    b = $urandom;
  endtask

  task automatic wait_done(output int lat, output int busy_cnt);
    lat = 0;
    busy_cnt = busy ? 1 : 0;
    while (!done && lat < 200) begin
      @(posedge clk);
      #1;
      lat++;
      if (busy) busy_cnt++;
      if (busy && done) chk("busy_and_done", 32'd1, 32'd0);
    end
    if (!done) chk("done_timeout", {31'd0, done}, 32'd1);
  endtask

  task automatic expected_latency(input logic [31:0] bv, output int lat);
    lat = (EARLY && bv == 32'd0) ? 1 : 33;
  endtask

  initial begin
    int lat, bcnt, exp_lat, seen;

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'd7,          32'hFFFFFFFE,   32'hFFFFFFFD,   32'd1,          1'b0};
    vecs[2] = '{32'hFFFFFFF9,   32'd2,          32'hFFFFFFFD,   32'hFFFFFFFF,   1'b0};
    vecs[3] = '{32'hFFFFFFF9,   32'hFFFFFFFE,   32'd3,          32'hFFFFFFFF,   1'b0};
    vecs[4] = '{32'h80000000,   32'hFFFFFFFF,   32'h80000000,   32'd0,          1'b0};
    vecs[5] = '{32'h00001234,   32'd0,          32'hFFFFFFFF,   32'h00001234,   1'b1};
    vecs[6] = '{32'hFFFFFF9C,   32'd7,          32'hFFFFFFF2,   32'hFFFFFFFE,   1'b0};
    vecs[7] = '{32'd5,          32'hFFFFFFF9,   32'd0,          32'd5,          1'b0};
    vecs[8] = '{32'h7FFFFFFF,   32'd1,          32'h7FFFFFFF,   32'd0,          1'b0};
    vecs[9] = '{32'hFFFFFFFF,   32'd0,          32'hFFFFFFFF,   32'hFFFFFFFF,   1'b1};

    #1;
    chk("reset_q", q, 32'd0);
    chk("reset_r", r, 32'd0);
    chk("reset_busy", {31'd0, busy}, 32'd0);
    chk("reset_done", {31'd0, done}, 32'd0);
    chk("reset_dbz", {31'd0, dbz}, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      launch(vecs[i].a, vecs[i].b);
      wait_done(lat, bcnt);
      expected_latency(vecs[i].b, exp_lat);
      chk($sformatf("v%0d_q", i), q, vecs[i].q);
      chk($sformatf("v%0d_r", i), r, vecs[i].r);
      chk($sformatf("v%0d_dbz", i), {31'd0, dbz}, {31'd0, vecs[i].dbz});
      chk($sformatf("v%0d_latency", i), lat, exp_lat);
      chk($sformatf("v%0d_busy_cycles", i), bcnt, exp_lat);
      @(posedge clk);
      #1;
      chk($sformatf("v%0d_done_pulse", i), {31'd0, done}, 32'd0);
      chk($sformatf("v%0d_q_hold", i), q, vecs[i].q);
    end

    // start while busy is ignored
    @(negedge clk);
    launch(32'd100, 32'd7);
    repeat (9) @(posedge clk);
    #1;
    launch(32'd50, 32'd3);
    wait_done(lat, bcnt);
    chk("ignore_q", q, 32'd14);
    chk("ignore_r", r, 32'd2);
    chk("ignore_latency", lat + 10, 33);
    repeat (40) @(posedge clk);
    #1;
    chk("ignore_no_second_run_q", q, 32'd14);

    // start during the done cycle is accepted
    @(negedge clk);
    launch(32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("b2b_first_q", q, 32'd14);
    launch(32'hFFFFFFF9, 32'd2);
    wait_done(lat, bcnt);
    chk("b2b_second_latency", lat, 33);
    chk("b2b_second_q", q, 32'hFFFFFFFD);
    chk("b2b_second_r", r, 32'hFFFFFFFF);

    // mid-run reset aborts immediately
    @(negedge clk);
    launch(32'd100, 32'd7);
    repeat (14) @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    chk("abort_q", q, 32'd0);
    chk("abort_r", r, 32'd0);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    chk("abort_done", {31'd0, done}, 32'd0);
    chk("abort_dbz", {31'd0, dbz}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (done || busy) seen++;
    end
    chk("abort_no_done", seen, 0);
    @(negedge clk);
    launch(32'd100, 32'd7);
    wait_done(lat, bcnt);
    chk("post_reset_q", q, 32'd14);
    chk("post_reset_r", r, 32'd2);
    chk("post_reset_latency", lat, 33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/signed_divider.md
# signed_divider

Serial signed integer divider, one quotient bit per clock (radix-2 restoring, sign-magnitude). It is the inverse companion of the team's serial Booth multiplier and sits beside it in the arithmetic unit. It accepts a dividend/divisor pair on `start`, iterates for WIDTH cycles, and returns a quotient and remainder with a one-cycle `done` pulse. Quotient truncates toward zero; the remainder takes the sign of the dividend.

## Interface
- WIDTH, 32, operand/result width in bits (≥ 4)
- clk  in  1  system clock, all state on rising edge
- rst_n  in  1  reset; one clock; reset is asynchronous and active-low
- start  in  1  operands valid; accepted only when idle
- a  in  WIDTH  dividend, two's complement
- b  in  WIDTH  divisor, two's complement
- q  out  WIDTH  quotient, registered
- r  out  WIDTH  remainder, registered
- busy  out  1  high while a division is in progress
- done  out  1  one-cycle pulse; q/r/dbz valid from this cycle until the next `done`
- dbz  out  1  divide-by-zero flag for the result presented with `done`

## Operation
- States: IDLE, CALC, FIX.
- IDLE, start=1: latch |a| into the quotient/dividend shift register and |b| into the divisor register. Latch sign_q = a[MSB]^b[MSB], sign_r = a[MSB], zero = (b==0). Clear the partial remainder (WIDTH+1 bits) and the counter. Go to CALC.
- CALC, each cycle:
  - Shift {rem, dvd} left 1.
  - trial = rem − {0,divisor} on the WIDTH+1-bit subtractor.
  - If trial ≥ 0: rem = trial and the new quotient LSB = 1. Otherwise rem is kept and the LSB = 0.
  - counter++. After WIDTH iterations, go to FIX.
- FIX:
  - q = sign_q ? −mag_q : mag_q; r = sign_r ? −rem : rem (WIDTH-bit, wrap).
  - If zero: force q = all ones, r = a (latched), dbz = 1. Otherwise dbz = 0.
  - done = 1. Go to IDLE.
- Overflow: −2^(WIDTH−1) / −1 gives q = −2^(WIDTH−1) (wrap) and r = 0, with no flag.
- `start` while busy is ignored. `a` and `b` may change freely after acceptance.
- `start` in the cycle `done` is high is accepted; the state is IDLE that cycle.
- q, r and dbz hold their values until the next FIX.

## Timing
- Reset values: q=0, r=0, busy=0, done=0, dbz=0, state IDLE, counter=0.
- Edge E0 samples start=1. E1..E_WIDTH perform the iterations. E_WIDTH+1 performs FIX.
- `done` is high between E_WIDTH+1 and E_WIDTH+2, so latency is WIDTH+1 cycles (33 at default).
- busy = (state != IDLE): high from E0 to E_WIDTH+1. busy and done are never high together.
- Back-to-back throughput: one result per WIDTH+2 cycles.
- rst_n low mid-operation aborts immediately. No `done` is issued and outputs return to reset values.

## Configuration
- `SIGNED_DIVIDER_EARLY_DBZ_EN` defined: if the divisor is zero at acceptance, skip CALC and go from IDLE straight to FIX. `done` then arrives at E1 (latency 1), with the same forced q/r/dbz values.
- Not defined: a divisor of zero runs the full WIDTH iterations. The result is still forced to the same values, and latency is WIDTH+1.

## Structure
- Shared package `divider_pkg`:
  - state enum typedef (IDLE/CALC/FIX)
  - default width constant DIV_W = 32
  - counter width constant $clog2(DIV_W)+1
- One sub-module, `div_sub_stage`: combinational WIDTH+1-bit trial subtract. It returns the difference and a non-negative flag, and pairs with the multiplier's adder.
- Sign-magnitude conversion and FIX negation live in the top level.

## Test plan
- 100 / 7 -> q=14, r=2, done at cycle 33 after start, busy high 33 cycles.
- 7 / −2 -> q=0xFFFFFFFD, r=1. −7 / 2 -> q=0xFFFFFFFD, r=0xFFFFFFFF. −7 / −2 -> q=3, r=0xFFFFFFFF.
- 0x80000000 / 0xFFFFFFFF -> q=0x80000000, r=0, dbz=0.
- 0x1234 / 0 -> q=0xFFFFFFFF, r=0x1234, dbz=1. Latency is 1 cycle with `SIGNED_DIVIDER_EARLY_DBZ_EN` defined and 33 cycles without.
- Second `start` with new operands at cycle 10 of a run -> ignored, first result unchanged. `start` during the `done` cycle -> accepted, next `done` 33 cycles later.
- rst_n pulsed low at cycle 15 of a run -> all outputs 0 immediately, no `done`. A fresh start then completes normally.
